iiitb_brg_ctrl: RTL and testbench

Rate-change controller and arbiter for the baud rate generator (iiitb_brg).
- Two requesters share one generator; requests are granted round-robin.
- A granted change is deferred until the downstream serial path is quiet. The controller then holds the generator in reset, drives the new sel, and waits for the first clkout rising edge as lock confirmation before acknowledging.
- On reset release it also performs the startup bring-up of the generator with DEFAULT_SEL.

---
 rtl/iiitb_brg_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_iiitb_brg_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_brg_ctrl.sv
// ---------------------------------------------------------------------------
// iiitb_brg_ctrl
//
// Rate-change controller and round-robin arbiter for the iiitb_brg baud rate
// generator. Two requesters ask for a new rate select. A granted change waits
// until the downstream serial path is quiet. The controller then holds the
// generator in reset for RST_CYCLES clocks and drives the new select. The
// first clkout rising edge confirms lock, and the requester is then
// acknowledged.
// After reset release the same APPLY/LOCK sequence brings the generator up
// with DEFAULT_SEL. No requester is acknowledged for that sequence.
//
// Parameters:
//   RST_CYCLES   - clk cycles brg_reset is held high per change (1..255)
//   LOCK_TIMEOUT - max clk cycles spent in LOCK waiting for a clkout edge
//   DEFAULT_SEL  - rate select applied at startup
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-low reset
//   req0/sel0    in   requester 0 level request (held until ack0) + select
//   req1/sel1    in   requester 1 level request (held until ack1) + select
//   busy_in      in   downstream frame in progress; defers new grants
//   brg_clkout   in   generator clkout, synchronous to clk
//   brg_reset    out  active-high reset to the generator
//   brg_sel      out  rate select to the generator
//   ack0/ack1    out  one-cycle completion pulses
//   locked       out  generator running at brg_sel, lock confirmed
//   err_timeout  out  sticky, last change failed to lock
//   chg_count    out  (BRG_CHG_CNT_EN only) saturating count of successful
//                     requested changes
//
// Optional feature macro: BRG_CHG_CNT_EN adds the chg_count output.
// ---------------------------------------------------------------------------
module iiitb_brg_ctrl #(
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter logic [1:0]  DEFAULT_SEL  = 2'b00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [1:0] sel0,
    input  logic       req1,
    input  logic [1:0] sel1,
    input  logic       busy_in,
    input  logic       brg_clkout,
    output logic       brg_reset,
    output logic [1:0] brg_sel,
    output logic       ack0,
    output logic       ack1,
    output logic       locked,
    output logic       err_timeout
`ifdef BRG_CHG_CNT_EN
    ,
    output logic [7:0] chg_count
`endif
);

    localparam logic [15:0] LP_RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LP_TO_LAST  = 16'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_LOCK  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Registered state and outputs
    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_brg_reset;
    logic [1:0]  r_brg_sel;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_locked;
    logic        r_err;
    logic        r_rr_last;
    logic        r_clk_prev;
    logic        r_gnt_id;     // requester owning the change in flight
    logic        r_gnt_valid;  // 0 for the startup sequence (no ack)

    // Next-state values
    state_t      w_state;
    logic [15:0] w_cnt;
    logic        w_brg_reset;
    logic [1:0]  w_brg_sel;
    logic        w_ack0;
    logic        w_ack1;
    logic        w_locked;
    logic        w_err;
    logic        w_rr_last;
    logic        w_gnt_id;
    logic        w_gnt_valid;
    logic        w_pick;
    logic [1:0]  w_req_sel;
    logic        w_edge;
    logic        w_grant_ok;

    // The ack cycle is an IDLE cycle in which the acknowledged requester
    // still holds req high. Grants are suppressed in that cycle, so a stale
    // req is not re-served and an ack never coincides with another grant.
    assign w_edge     = brg_clkout & ~r_clk_prev;
    assign w_grant_ok = ~busy_in & (req0 | req1) & ~r_ack0 & ~r_ack1;

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_brg_reset = r_brg_reset;
        w_brg_sel   = r_brg_sel;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        w_locked    = r_locked;
        w_err       = r_err;
        w_rr_last   = r_rr_last;
        w_gnt_id    = r_gnt_id;
        w_gnt_valid = r_gnt_valid;
        w_pick      = 1'b0;
        w_req_sel   = sel0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_grant_ok) begin
                    // Tie goes to the requester not served last
                    if (req0 && req1) begin
                        w_pick = ~r_rr_last;
                    end else begin
                        w_pick = req1;
                    end
                    w_req_sel   = w_pick ? sel1 : sel0;
                    w_rr_last   = w_pick;
                    w_gnt_id    = w_pick;
                    w_gnt_valid = 1'b1;
                    w_err       = 1'b0;
                    if ((w_req_sel == r_brg_sel) && r_locked) begin
                        // Already running and locked at this rate
                        w_state = ST_DONE;
                    end else begin
                        w_brg_sel   = w_req_sel;
                        w_brg_reset = 1'b1;
                        w_locked    = 1'b0;
                        w_cnt       = '0;
                        w_state     = ST_APPLY;
                    end
                end
            end

            ST_APPLY: begin
                if (r_cnt == LP_RST_LAST) begin
                    w_brg_reset = 1'b0;
                    w_cnt       = '0;
                    w_state     = ST_LOCK;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end

            ST_LOCK: begin
                // An edge on the timeout cycle still counts as lock
                if (w_edge) begin
                    w_locked = 1'b1;
                    w_state  = ST_DONE;
                end else if (r_cnt == LP_TO_LAST) begin
                    w_err   = 1'b1;
                    w_state = ST_DONE;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end

            ST_DONE: begin
                if (r_gnt_valid) begin
                    w_ack0 = ~r_gnt_id;
                    w_ack1 = r_gnt_id;
                end
                w_gnt_valid = 1'b0;
                w_state     = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_APPLY;
            r_cnt       <= '0;
            r_brg_reset <= 1'b1;
            r_brg_sel   <= DEFAULT_SEL;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_rr_last   <= 1'b1;
            r_clk_prev  <= 1'b0;
            r_gnt_id    <= 1'b0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_brg_reset <= w_brg_reset;
            r_brg_sel   <= w_brg_sel;
            r_ack0      <= w_ack0;
            r_ack1      <= w_ack1;
            r_locked    <= w_locked;
            r_err       <= w_err;
            r_rr_last   <= w_rr_last;
            r_clk_prev  <= brg_clkout;
            r_gnt_id    <= w_gnt_id;
            r_gnt_valid <= w_gnt_valid;
        end
    end

    assign brg_reset   = r_brg_reset;
    assign brg_sel     = r_brg_sel;
    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign locked      = r_locked;
    assign err_timeout = r_err;

`ifdef BRG_CHG_CNT_EN
    logic [7:0] r_chg_count;

    // DONE with lock held and a requester owning the change: covers locked
    // changes and fast acks, excludes timeouts and startup.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_chg_count <= '0;
        end else if ((r_state == ST_DONE) && r_gnt_valid && r_locked &&
                     (r_chg_count != 8'hFF)) begin
            r_chg_count <= r_chg_count + 8'd1;
        end
    end

    assign chg_count = r_chg_count;
`endif

endmodule

// File: tb/tb_iiitb_brg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iiitb_brg_ctrl
//
// Bench for iiitb_brg_ctrl with RST_CYCLES=4 and LOCK_TIMEOUT=8. A clocked
// stub stands in for the generator and pulses clkout once, three cycles
// after brg_reset falls, while stub_en is set. The expected completion of
// each request is queued when the request is driven. The monitor pops and
// compares an entry on every ack pulse.
// ---------------------------------------------------------------------------
module tb_iiitb_brg_ctrl;

    localparam int RST   = 4;
    localparam int TO    = 8;
    localparam int DLY   = 2;             // stub count at which clkout is raised
    localparam int NORM  = RST + DLY + 4; // grant -> ack, locked change
    localparam int SLOCK = RST + DLY + 2; // reset release -> locked, startup
    localparam int TMO   = RST + TO + 2;  // grant -> ack, timed out change
    localparam int FAST  = 2;             // grant -> ack, fast path

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       req0       = 1'b0;
    logic [1:0] sel0       = 2'b00;
    logic       req1       = 1'b0;
    logic [1:0] sel1       = 2'b00;
    logic       busy_in    = 1'b0;
    logic       brg_clkout = 1'b0;
    logic       brg_reset;
    logic [1:0] brg_sel;
    logic       ack0;
    logic       ack1;
    logic       locked;
    logic       err_timeout;
`ifdef BRG_CHG_CNT_EN
    logic [7:0] chg_count;
`endif

    logic stub_en  = 1'b1;
    int   stub_cnt = 0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_chg    = 0;
    int   rst_run  = 0;

    typedef struct {
        logic       id;
        logic [1:0] sel;
        logic       lk;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    iiitb_brg_ctrl #(
        .RST_CYCLES  (RST),
        .LOCK_TIMEOUT(TO),
        .DEFAULT_SEL (2'b00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .sel0       (sel0),
        .req1       (req1),
        .sel1       (sel1),
        .busy_in    (busy_in),
        .brg_clkout (brg_clkout),
        .brg_reset  (brg_reset),
        .brg_sel    (brg_sel),
        .ack0       (ack0),
        .ack1       (ack1),
        .locked     (locked),
        .err_timeout(err_timeout)
`ifdef BRG_CHG_CNT_EN
        ,
        .chg_count  (chg_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Generator stub: one-cycle clkout pulse DLY+1 cycles after reset falls
    always @(posedge clk) begin
        if (brg_reset !== 1'b0) begin
            stub_cnt   <= 0;
            brg_clkout <= 1'b0;
        end else if (!stub_en) begin
            brg_clkout <= 1'b0;
        end else begin
            brg_clkout <= (stub_cnt == DLY);
            if (stub_cnt < 100) stub_cnt <= stub_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic id, input logic [1:0] sel,
                            input logic lk, input logic err, input int c);
        exp_t e;
        e.id  = id;
        e.sel = sel;
        e.lk  = lk;
        e.err = err;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait for this requester's ack, then drop its req the following cycle
    task automatic wait_ack(input logic id);
        logic got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((id && ack1) || (!id && ack0)) begin
                got = 1'b1;
                break;
            end
        end
        check_eq(id ? "ack1_seen" : "ack0_seen", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (id) req1 = 1'b0;
        else    req0 = 1'b0;
    endtask

    task automatic wait_locked(input int t0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (locked) break;
        end
        check_eq("startup_lock_cycle", cyc, t0 + SLOCK);
        check_eq("startup_sel", {30'b0, brg_sel}, 32'd0);
    endtask

    // Scoreboard monitor plus brg_reset pulse-width check
    always @(negedge clk) begin
        if (reset && (ack0 || ack1)) begin
            if (sb.size() == 0) begin
                check_eq("ack_unexpected", {30'b0, ack1, ack0}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("ack_id", {30'b0, ack1, ack0}, e.id ? 32'd2 : 32'd1);
                check_eq("ack_cycle", cyc, e.cyc);
                check_eq("ack_sel", {30'b0, brg_sel}, {30'b0, e.sel});
                check_eq("ack_locked", {31'b0, locked}, {31'b0, e.lk});
                check_eq("ack_err", {31'b0, err_timeout}, {31'b0, e.err});
                if (e.lk) n_chg++;
            end
        end
        if (reset && brg_reset) begin
            rst_run++;
        end else if (rst_run != 0) begin
            check_eq("brg_reset_width", rst_run, RST);
            rst_run = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int t;

        // Reset values and startup bring-up
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_brg_reset", {31'b0, brg_reset}, 32'd1);
        check_eq("rst_brg_sel", {30'b0, brg_sel}, 32'd0);
        check_eq("rst_locked", {31'b0, locked}, 32'd0);
        check_eq("rst_acks", {30'b0, ack1, ack0}, 32'd0);
        check_eq("rst_err", {31'b0, err_timeout}, 32'd0);
`ifdef BRG_CHG_CNT_EN
        check_eq("rst_chg_count", {24'b0, chg_count}, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        t = cyc;
        wait_locked(t);
        idle(2);

        // Contention, rr_last=1: req0 first, then req1
        t = cyc;
        push_exp(1'b0, 2'b01, 1'b1, 1'b0, t + NORM);
        push_exp(1'b1, 2'b11, 1'b1, 1'b0, t + 2 * NORM + 1);
        sel0 = 2'b01; sel1 = 2'b11;
        req0 = 1'b1;  req1 = 1'b1;
        wait_ack(1'b0);
        wait_ack(1'b1);
        idle(2);

        // Single change; sel0 altered after the grant cycle must be ignored
        t = cyc;
        push_exp(1'b0, 2'b10, 1'b1, 1'b0, t + NORM);
        sel0 = 2'b10;
        req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("single_brg_reset", {31'b0, brg_reset}, 32'd1);
        check_eq("single_brg_sel", {30'b0, brg_sel}, 32'd2);
        check_eq("single_locked_low", {31'b0, locked}, 32'd0);
        sel0 = 2'b01;
        wait_ack(1'b0);
        idle(2);

        // Contention, rr_last=0: req1 first this time
        t = cyc;
        push_exp(1'b1, 2'b01, 1'b1, 1'b0, t + NORM);
        push_exp(1'b0, 2'b00, 1'b1, 1'b0, t + 2 * NORM + 1);
        sel0 = 2'b00; sel1 = 2'b01;
        req0 = 1'b1;  req1 = 1'b1;
        wait_ack(1'b1);
        wait_ack(1'b0);
        idle(2);

        // Busy deferral: nothing moves for 20 cycles, grant when busy falls
        busy_in = 1'b1;
        sel1 = 2'b10;
        req1 = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_eq("busy_brg_reset", {31'b0, brg_reset}, 32'd0);
            check_eq("busy_brg_sel", {30'b0, brg_sel}, 32'd0);
        end
        @(posedge clk);
        #1;
        busy_in = 1'b0;
        t = cyc;
        push_exp(1'b1, 2'b10, 1'b1, 1'b0, t + NORM);
        wait_ack(1'b1);
        idle(2);

        // Lock timeout with a silent generator
        stub_en = 1'b0;
        t = cyc;
        push_exp(1'b0, 2'b11, 1'b0, 1'b1, t + TMO);
        sel0 = 2'b11;
        req0 = 1'b1;
        wait_ack(1'b0);
        idle(2);
        check_eq("timeout_err_sticky", {31'b0, err_timeout}, 32'd1);
        check_eq("timeout_unlocked", {31'b0, locked}, 32'd0);

        // Next successful change clears err_timeout at grant
        stub_en = 1'b1;
        t = cyc;
        push_exp(1'b1, 2'b01, 1'b1, 1'b0, t + NORM);
        sel1 = 2'b01;
        req1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("recover_err_cleared", {31'b0, err_timeout}, 32'd0);
        wait_ack(1'b1);
        idle(2);

        // Fast path: same sel while locked, no generator reset
        t = cyc;
        push_exp(1'b1, 2'b01, 1'b1, 1'b0, t + FAST);
        sel1 = 2'b01;
        req1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("fast_no_brg_reset", {31'b0, brg_reset}, 32'd0);
        wait_ack(1'b1);
        idle(2);
`ifdef BRG_CHG_CNT_EN
        check_eq("chg_count_total", {24'b0, chg_count}, n_chg);
`endif

        // Reset asserted while in LOCK aborts the change without an ack
        stub_en = 1'b0;
        t = cyc;
        sel0 = 2'b10;
        req0 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("midrst_in_lock", {31'b0, brg_reset}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("midrst_brg_sel", {30'b0, brg_sel}, 32'd0);
        check_eq("midrst_brg_reset", {31'b0, brg_reset}, 32'd1);
        check_eq("midrst_locked", {31'b0, locked}, 32'd0);
        check_eq("midrst_acks", {30'b0, ack1, ack0}, 32'd0);
`ifdef BRG_CHG_CNT_EN
        check_eq("midrst_chg_count", {24'b0, chg_count}, 32'd0);
`endif
        req0 = 1'b0;
        @(posedge clk);
        #1;
        stub_en = 1'b1;
        reset   = 1'b1;
        t = cyc;
        wait_locked(t);
        idle(10);
        check_eq("sb_drained", sb.size(), 32'd0);
`ifdef BRG_CHG_CNT_EN
        check_eq("final_chg_count", {24'b0, chg_count}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
